// File: rtl/alu_decode_stage.sv
// Decode stage for the logical/immediate MIPS subset, feeding the EX-stage ALU
// through a 2-entry ID/EX buffer with valid/ready handshake, stall and flush.
module alu_decode_stage (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] instr,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [7:0]  alucontrol,
   output logic [31:0] imm32,
   output logic [4:0]  rs,
   output logic [4:0]  rt,
   output logic [4:0]  writereg,
   output logic        alusrc,
   output logic        regwrite,
   output logic        illegal
);

   localparam logic [7:0] EXE_NOP_OP  = 8'b00000000;
   localparam logic [7:0] EXE_AND_OP  = 8'b00100100;
   localparam logic [7:0] EXE_OR_OP   = 8'b00100101;
   localparam logic [7:0] EXE_XOR_OP  = 8'b00100110;
   localparam logic [7:0] EXE_NOR_OP  = 8'b00100111;
   localparam logic [7:0] EXE_ANDI_OP = 8'b01011001;
   localparam logic [7:0] EXE_ORI_OP  = 8'b01011010;
   localparam logic [7:0] EXE_XORI_OP = 8'b01011011;
   localparam logic [7:0] EXE_LUI_OP  = 8'b01011100;

   typedef struct packed {
      logic [7:0]  alucontrol;
      logic [31:0] imm32;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  writereg;
      logic        alusrc;
      logic        regwrite;
      logic        illegal;
   } dec_t;

   dec_t       dec;
   dec_t       head;
   dec_t       mem [2];
   logic [1:0] count;
   logic       wr_ptr;
   logic       rd_ptr;
   logic       push;
   logic       pop;

   always_comb begin
      dec            = '0;
      dec.rs         = instr[25:21];
      dec.rt         = instr[20:16];
      dec.imm32      = {{16{instr[15]}}, instr[15:0]};
      dec.alucontrol = EXE_NOP_OP;
      if (instr != 32'h0000_0000) begin
         dec.illegal = 1'b1;
         unique case (instr[31:26])
            6'b000000: begin
               dec.illegal  = 1'b0;
               dec.regwrite = 1'b1;
               dec.writereg = instr[15:11];
               unique case (instr[5:0])
                  6'b100100: dec.alucontrol = EXE_AND_OP;
                  6'b100101: dec.alucontrol = EXE_OR_OP;
                  6'b100110: dec.alucontrol = EXE_XOR_OP;
                  6'b100111: dec.alucontrol = EXE_NOR_OP;
                  default: begin
                     dec.illegal  = 1'b1;
                     dec.regwrite = 1'b0;
                     dec.writereg = 5'd0;
                  end
               endcase
            end
            6'b001100: dec.alucontrol = EXE_ANDI_OP;
            6'b001101: dec.alucontrol = EXE_ORI_OP;
            6'b001110: dec.alucontrol = EXE_XORI_OP;
            6'b001111: dec.alucontrol = EXE_LUI_OP;
            default:   dec.alucontrol = EXE_NOP_OP;
         endcase
         // I-type ops are recognised by having picked a non-NOP code above
         if (instr[31:26] != 6'b000000 && dec.alucontrol != EXE_NOP_OP) begin
            dec.illegal  = 1'b0;
            dec.alusrc   = 1'b1;
            dec.regwrite = 1'b1;
            dec.writereg = instr[20:16];
         end
      end
   end

   assign in_ready  = (count != 2'd2);
   assign out_valid = (count != 2'd0);
   assign push      = in_valid & in_ready & ~flush;
   assign pop       = out_valid & out_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         count  <= 2'd0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         mem[0] <= '0;
         mem[1] <= '0;
      end else if (flush) begin
         count  <= 2'd0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= dec;
            wr_ptr      <= ~wr_ptr;
         end
         if (pop) rd_ptr <= ~rd_ptr;
         unique case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   // Empty buffer presents reset values, never stale entries
   assign head       = out_valid ? mem[rd_ptr] : '0;
   assign alucontrol = head.alucontrol;
   assign imm32      = head.imm32;
   assign rs         = head.rs;
   assign rt         = head.rt;
   assign writereg   = head.writereg;
   assign alusrc     = head.alusrc;
   assign regwrite   = head.regwrite;
   assign illegal    = head.illegal;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Bench for alu_decode_stage: decode vector table, directed buffer sequences,
// and a randomized run against a queue-based reference model.
module tb_alu_decode_stage;

   typedef struct packed {
      logic [7:0]  alucontrol;
      logic [31:0] imm32;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  writereg;
      logic        alusrc;
      logic        regwrite;
      logic        illegal;
   } dec_t;

   typedef struct {
      logic [31:0] instr;
      dec_t        exp;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] instr = 32'h0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [7:0]  alucontrol;
   logic [31:0] imm32;
   logic [4:0]  rs;
   logic [4:0]  rt;
   logic [4:0]  writereg;
   logic        alusrc;
   logic        regwrite;
   logic        illegal;

   int checks = 0;
   int errors = 0;
   vec_t vecs [9];
   dec_t model_q [$];

   always #5 clk = ~clk;

   alu_decode_stage dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
      .out_valid(out_valid), .out_ready(out_ready),
      .alucontrol(alucontrol), .imm32(imm32), .rs(rs), .rt(rt),
      .writereg(writereg), .alusrc(alusrc), .regwrite(regwrite),
      .illegal(illegal)
   );

   function automatic dec_t dut_out();
      return '{alucontrol, imm32, rs, rt, writereg, alusrc, regwrite, illegal};
   endfunction

   // Reference decode: R-type codes equal their funct value; I-type codes are
   // 0x59 plus the offset of the opcode from ANDI (12).
   function automatic dec_t ref_decode(logic [31:0] w);
      dec_t r = '0;
      int   op = int'(w[31:26]);
      int   fn = int'(w[5:0]);
      r.rs    = w[25:21];
      r.rt    = w[20:16];
      r.imm32 = {{16{w[15]}}, w[15:0]};
      if (w == 32'h0) return r;
      if (op == 0 && fn >= 36 && fn <= 39) begin
         r.alucontrol = 8'(fn);
         r.regwrite   = 1'b1;
         r.writereg   = w[15:11];
      end else if (op >= 12 && op <= 15) begin
         r.alucontrol = 8'(8'h59 + op - 12);
         r.alusrc     = 1'b1;
         r.regwrite   = 1'b1;
         r.writereg   = w[20:16];
      end else begin
         r.illegal = 1'b1;
      end
      return r;
   endfunction

   task automatic check_dec(string name, dec_t exp);
      dec_t act = dut_out();
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_bit(string name, logic act, logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_empty(string name);
      check_bit({name, "_out_valid"}, out_valid, 1'b0);
      check_bit({name, "_in_ready"}, in_ready, 1'b1);
      check_dec({name, "_fields"}, '0);
   endtask

   initial begin
      // {instr, {alucontrol, imm32, rs, rt, writereg, alusrc, regwrite, illegal}}
      vecs[0] = '{32'h00851025, '{8'h25, 32'h00001025, 5'd4, 5'd5, 5'd2, 1'b0, 1'b1, 1'b0}};
      vecs[1] = '{32'h352800FF, '{8'h5A, 32'h000000FF, 5'd9, 5'd8, 5'd8, 1'b1, 1'b1, 1'b0}};
      vecs[2] = '{32'h30638000, '{8'h59, 32'hFFFF8000, 5'd3, 5'd3, 5'd3, 1'b1, 1'b1, 1'b0}};
      vecs[3] = '{32'h3C011234, '{8'h5C, 32'h00001234, 5'd0, 5'd1, 5'd1, 1'b1, 1'b1, 1'b0}};
      vecs[4] = '{32'h00851027, '{8'h27, 32'h00001027, 5'd4, 5'd5, 5'd2, 1'b0, 1'b1, 1'b0}};
      vecs[5] = '{32'h8C220000, '{8'h00, 32'h00000000, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 1'b1}};
      vecs[6] = '{32'h00000000, '{8'h00, 32'h00000000, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0}};
      vecs[7] = '{32'h38A5FFFF, '{8'h5B, 32'hFFFFFFFF, 5'd5, 5'd5, 5'd5, 1'b1, 1'b1, 1'b0}};
      vecs[8] = '{32'h012A4024, '{8'h24, 32'h00004024, 5'd9, 5'd10, 5'd8, 1'b0, 1'b1, 1'b0}};

      tick(); tick();
      rst = 1'b0;
      check_empty("reset");

      // Single push then pop of each table vector
      foreach (vecs[i]) begin
         instr = vecs[i].instr; in_valid = 1'b1; out_ready = 1'b1;
         tick();
         in_valid = 1'b0;
         check_bit($sformatf("vec%0d_valid", i), out_valid, 1'b1);
         check_dec($sformatf("vec%0d_fields", i), vecs[i].exp);
         tick();
         check_bit($sformatf("vec%0d_drained", i), out_valid, 1'b0);
      end

      // Backpressure: fill to two, third push refused, drain in order
      out_ready = 1'b0; in_valid = 1'b1; instr = vecs[3].instr;
      tick();
      check_bit("bp_ready_after_1", in_ready, 1'b1);
      instr = vecs[4].instr;
      tick();
      check_bit("bp_ready_after_2", in_ready, 1'b0);
      check_dec("bp_head_lui", vecs[3].exp);
      instr = vecs[8].instr;
      tick();
      check_bit("bp_third_refused", in_ready, 1'b0);
      check_dec("bp_head_still_lui", vecs[3].exp);
      in_valid = 1'b0; out_ready = 1'b1;
      tick();
      check_dec("bp_head_nor", vecs[4].exp);
      tick();
      check_empty("bp_drained");

      // Flush at full with simultaneous push and pop
      out_ready = 1'b0; in_valid = 1'b1; instr = vecs[0].instr;
      tick(); tick();
      check_bit("fl_full", in_ready, 1'b0);
      flush = 1'b1; out_ready = 1'b1; instr = vecs[1].instr;
      tick();
      flush = 1'b0; in_valid = 1'b0;
      check_empty("flush");

      // Reset with one entry buffered
      in_valid = 1'b1; out_ready = 1'b0; instr = vecs[2].instr;
      tick();
      in_valid = 1'b0; rst = 1'b1;
      tick();
      rst = 1'b0;
      check_empty("rst_mid");

      // Back-to-back push/pop at count 1
      in_valid = 1'b1; instr = vecs[0].instr;
      tick();
      out_ready = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         instr = vecs[i].instr;
         tick();
         check_bit($sformatf("b2b%0d_ready", i), in_ready, 1'b1);
         check_dec($sformatf("b2b%0d_head", i), vecs[i].exp);
      end
      in_valid = 1'b0;
      tick();
      check_empty("b2b_drained");

      // Randomized run against the queue model
      model_q.delete();
      for (int c = 0; c < 3000; c++) begin
         bit acc, pp;
         dec_t exp;
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         flush     = ($urandom_range(0, 40) == 0);
         case ($urandom_range(0, 3))
            0: instr = $urandom();
            1: instr = vecs[$urandom_range(0, 8)].instr;
            2: instr = {6'b000000, 20'($urandom()), 6'($urandom_range(32, 41))};
            default: instr = {6'($urandom_range(10, 16)), 26'($urandom())};
         endcase
         acc = in_valid && (model_q.size() < 2) && !flush;
         pp  = (model_q.size() > 0) && out_ready;
         tick();
         if (flush) model_q.delete();
         else begin
            if (pp) void'(model_q.pop_front());
            if (acc) model_q.push_back(ref_decode(instr));
         end
         exp = (model_q.size() > 0) ? model_q[0] : '0;
         check_bit("rnd_out_valid", out_valid, model_q.size() > 0);
         check_bit("rnd_in_ready", in_ready, model_q.size() < 2);
         check_dec("rnd_head", exp);
      end
      in_valid = 1'b0; flush = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_decode_stage.md
Name: alu_decode_stage

Overview:
- Decode-side producer of the `alucontrol` interface consumed by the EX-stage ALU.
- Accepts 32-bit MIPS instructions over a valid/ready handshake and decodes the logical/immediate subset (AND, OR, XOR, NOR, ANDI, ORI, XORI, LUI).
- Delivers the `defines.vh` 8-bit op code plus operand/writeback control through a 2-entry ID/EX buffer.
- Supports stall (backpressure) and flush.

Parameters:
- DEPTH, 2, entries in the ID/EX buffer; fixed at 2, with `full` when count==2.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  discards all buffered entries and any same-cycle input.
- in_valid  input  1  instruction present on `instr`.
- in_ready  output  1  buffer can accept; equals count<2.
- instr  input  32  raw instruction word.
- out_valid  output  1  head entry valid; equals count>0.
- out_ready  input  1  EX stage consumes the head entry.
- alucontrol  output  8  `EXE_*_OP` code for the ALU.
- imm32  output  32  sign-extended `instr[15:0]`; the ALU zero-extends for ANDI/ORI/XORI and uses [15:0] for LUI.
- rs  output  5  `instr[25:21]`.
- rt  output  5  `instr[20:16]`.
- writereg  output  5  rd for R-type, rt for I-type, 0 otherwise.
- alusrc  output  1  1 = ALU b operand comes from imm32.
- regwrite  output  1  result is written back.
- illegal  output  1  opcode/funct not supported by this stage.

Behaviour:
- Decode is combinational on `instr`. The result is written into the buffer tail on accept (`in_valid & in_ready & ~flush`).
- Outputs always show the head entry. Latency from accept to `out_valid` is 1 cycle.
- Op codes:
  - AND 8'b00100100, OR 8'b00100101, XOR 8'b00100110, NOR 8'b00100111
  - ANDI 8'b01011001, ORI 8'b01011010, XORI 8'b01011011, LUI 8'b01011100
  - NOP 8'b00000000
- R-type (opcode 000000) funct mapping: 100100/100101/100110/100111 → AND/OR/XOR/NOR, with alusrc=0, regwrite=1, writereg=rd.
- I-type opcode mapping: 001100/001101/001110/001111 → ANDI/ORI/XORI/LUI, with alusrc=1, regwrite=1, writereg=rt.
- Instruction 32'h00000000 → NOP: regwrite=0, illegal=0, writereg=0.
- Any other encoding → NOP with regwrite=0, illegal=1, writereg=0. Still accepted and passed downstream.
- Buffer behaviour:
  - Pop on `out_valid & out_ready`.
  - Simultaneous push and pop: count unchanged, order preserved (FIFO). Allowed when count==2 only if `in_ready` permits; in_ready is 0 at count==2, so a push at full never happens.
  - At count==0, a push and an out_ready in the same cycle do not bypass: the entry appears the next cycle.
  - Push and pop pointers wrap modulo 2.
- Flush:
  - Next cycle count=0 and out_valid=0, regardless of same-cycle push/pop.
  - Flush has priority over everything except rst.
- Reset values (next edge after rst=1): count=0, pointers=0, out_valid=0, in_ready=1.
  - Output fields while empty: alucontrol=NOP, imm32=0, rs=0, rt=0, writereg=0, alusrc=0, regwrite=0, illegal=0.
  - Reset mid-stream discards all entries.
- When empty, all output fields are forced to the reset values; never stale data.

Test Plan:
- Reset, then push 32'h00851025 (`or $2,$4,$5`) with out_ready=1 → next cycle out_valid=1, alucontrol=8'b00100101, rs=4, rt=5, writereg=2, alusrc=0, regwrite=1, illegal=0.
- Push 32'h352800FF (`ori $8,$9,0xff`) → alucontrol=8'b01011010, imm32=32'h000000FF, writereg=8, alusrc=1. Push 32'h30638000 (`andi`) → imm32=32'hFFFF8000, alucontrol=8'b01011001.
- Hold out_ready=0 and push 32'h3C011234 then 32'h00851027 → in_ready drops to 0 after the second push; a third in_valid is not accepted. Release out_ready → LUI (8'b01011100) pops, then NOR (8'b00100111), in order.
- Push 32'h8C220000 (`lw`) → illegal=1, alucontrol=NOP, regwrite=0. Push 32'h00000000 → illegal=0, regwrite=0.
- Fill to 2 entries, then assert flush together with in_valid=1 and out_ready=1 → next cycle out_valid=0, in_ready=1, outputs at reset values.
- Assert rst with 1 entry buffered → next cycle out_valid=0 and alucontrol=NOP. Back-to-back push/pop at count==1 for 8 cycles → count stays 1 and every instruction emerges exactly once, in order.
